// File: rtl/ahfp_norm_arb.sv
// ahfp_norm_arb: two-requester arbiter in front of a shared 48-bit leading-zero
// detector. Each accepted operand passes through the detect, shift and
// exponent-adjust stages, and the normalised result is then held on a
// valid/ready port.

// ahfp_lzd48: combinational leading-zero count from bit 47.
// vld is high when any bit of din is set.
module ahfp_lzd48 (
    input  logic [47:0] din,
    output logic [5:0]  lz,
    output logic        vld
);

    // Scan upward so that the highest set bit is the last one to write lz.
    always_comb begin
        lz  = '0;
        vld = 1'b0;
        for (int unsigned i = 0; i < 48; i++) begin
            if (din[i]) begin
                lz  = 6'(47 - i);
                vld = 1'b1;
            end
        end
    end

endmodule

module ahfp_norm_arb #(
    parameter int MW = 48,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [MW-1:0] req0_man,
    input  logic [EW-1:0] req0_exp,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [MW-1:0] req1_man,
    input  logic [EW-1:0] req1_exp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_man,
    output logic [EW-1:0] out_exp,
    output logic          out_zero,
    output logic          out_uflow,
    output logic          out_src
);

    typedef enum logic [1:0] {IDLE, DETECT, SHIFT, HOLD} state_t;

    state_t        state;
    logic          last;
    logic [MW-1:0] cap_man;
    logic [EW-1:0] cap_exp;
    logic [5:0]    lz_q;
    logic          lzv_q;

    logic [5:0]    lz_c;
    logic          lzv_c;
    logic          grant_any;
    logic          grant_idx;

    logic [EW:0]   exp_w;
    logic [EW:0]   lz_w;
    logic [EW:0]   diff_w;
    logic [EW:0]   ushift;
    logic [MW-1:0] n_man;
    logic [EW-1:0] n_exp;
    logic          n_zero;
    logic          n_uflow;

    ahfp_lzd48 u_lzd (
        .din (cap_man),
        .lz  (lz_c),
        .vld (lzv_c)
    );

    // Round-robin grant: a tie goes to the requester not served last.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_idx  = (req0_valid & req1_valid) ? ~last : req1_valid;
        req0_ready = ~rst & (state == IDLE) & grant_any & ~grant_idx;
        req1_ready = ~rst & (state == IDLE) & grant_any &  grant_idx;
    end

    // Normalise the captured operand: shift by lz, or clamp to a denormal when
    // the exponent cannot absorb the full shift.
    always_comb begin
        exp_w   = {1'b0, cap_exp};
        lz_w    = {{(EW - 5){1'b0}}, lz_q};
        diff_w  = exp_w - lz_w;
        ushift  = (cap_exp == '0) ? '0 : exp_w - 1'b1;
        n_man   = '0;
        n_exp   = '0;
        n_zero  = 1'b0;
        n_uflow = 1'b0;
        if (!lzv_q) begin
            n_zero = 1'b1;
        end else if (lz_w < exp_w) begin
            n_man = cap_man << lz_q;
            n_exp = diff_w[EW-1:0];
        end else begin
            n_man   = cap_man << ushift;
            n_uflow = 1'b1;
        end
    end

    // Sequencer: accept, detect, shift, then hold the result until it is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            cap_man   <= '0;
            cap_exp   <= '0;
            lz_q      <= '0;
            lzv_q     <= 1'b0;
            out_valid <= 1'b0;
            out_man   <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
            out_src   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cap_man <= grant_idx ? req1_man : req0_man;
                        cap_exp <= grant_idx ? req1_exp : req0_exp;
                        out_src <= grant_idx;
                        last    <= grant_idx;
                        state   <= DETECT;
                    end
                end
                DETECT: begin
                    lz_q  <= lz_c;
                    lzv_q <= lzv_c;
                    state <= SHIFT;
                end
                SHIFT: begin
                    out_man   <= n_man;
                    out_exp   <= n_exp;
                    out_zero  <= n_zero;
                    out_uflow <= n_uflow;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahfp_norm_arb.sv
// tb_ahfp_norm_arb: randomized and directed stimulus for ahfp_norm_arb, with a
// scoreboard fed by a behavioural normalisation model and a round-robin
// arbitration model.
module tb_ahfp_norm_arb;

    typedef struct {
        logic [47:0] man;
        logic [7:0]  exp;
    } item_t;

    typedef struct {
        logic [47:0] man;
        logic [7:0]  exp;
        logic        zero;
        logic        uflow;
        logic        src;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [47:0] req0_man, req1_man, out_man;
    logic [7:0]  req0_exp, req1_exp, out_exp;
    logic        out_valid, out_ready, out_zero, out_uflow, out_src;

    item_t q0[$];
    item_t q1[$];
    res_t  sb[$];

    int    checks = 0;
    int    fails = 0;
    int    cyc = 0;
    int    hs_cyc = 0;
    int    hs_count = 0;
    int    pct = 100;
    int    drop_pct = 0;
    logic  busy_m = 1'b0;
    logic  last_m = 1'b1;
    logic  hs0 = 1'b0;
    logic  hs1 = 1'b0;

    ahfp_norm_arb #(.MW(48), .EW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_man   (req0_man),
        .req0_exp   (req0_exp),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_man   (req1_man),
        .req1_exp   (req1_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_man    (out_man),
        .out_exp    (out_exp),
        .out_zero   (out_zero),
        .out_uflow  (out_uflow),
        .out_src    (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: count leading zeros, then shift or clamp using integer arithmetic.
    function automatic res_t model(input logic [47:0] m, input logic [7:0] e, input logic s);
        res_t r;
        int   lz;
        int   ei;
        r.src   = s;
        r.zero  = 1'b0;
        r.uflow = 1'b0;
        r.man   = '0;
        r.exp   = '0;
        ei      = int'(e);
        lz      = 0;
        while (lz < 48 && m[47 - lz] == 1'b0) lz++;
        if (lz == 48) begin
            r.zero = 1'b1;
        end else if (lz < ei) begin
            r.man = m << lz;
            r.exp = 8'(ei - lz);
        end else begin
            r.man   = m << ((ei == 0) ? 0 : ei - 1);
            r.uflow = 1'b1;
        end
        return r;
    endfunction

    task automatic push(input int who, input logic [47:0] m, input logic [7:0] e);
        item_t it;
        it.man = m;
        it.exp = e;
        if (who == 0) q0.push_back(it);
        else q1.push_back(it);
    endtask

    function automatic logic drained();
        return q0.size() == 0 && q1.size() == 0 && !busy_m && !req0_valid && !req1_valid;
    endfunction

    task automatic drain(input int bound);
        int n = 0;
        while (!drained() && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (!drained()) begin
            fails++;
            $display("FAIL drain_timeout: got pending work expected idle after %0d cycles", bound);
        end
    endtask

    // Requester drivers: present the head of each queue, pop it on handshake,
    // and occasionally drop valid before being granted.
    always @(posedge clk) begin
        #1;
        if (hs0) begin
            q0.delete(0);
            req0_valid = 1'b0;
        end else if (req0_valid && $urandom_range(0, 99) < drop_pct) begin
            req0_valid = 1'b0;
        end
        if (!req0_valid && q0.size() > 0 && $urandom_range(0, 99) < pct) begin
            req0_valid = 1'b1;
            req0_man   = q0[0].man;
            req0_exp   = q0[0].exp;
        end
        if (hs1) begin
            q1.delete(0);
            req1_valid = 1'b0;
        end else if (req1_valid && $urandom_range(0, 99) < drop_pct) begin
            req1_valid = 1'b0;
        end
        if (!req1_valid && q1.size() > 0 && $urandom_range(0, 99) < pct) begin
            req1_valid = 1'b1;
            req1_man   = q1[0].man;
            req1_exp   = q1[0].exp;
        end
    end

    // Monitor: compare readies and outputs mid-cycle against the models, then
    // record the handshakes that take place on the coming edge.
    always @(negedge clk) begin
        logic er0;
        logic er1;
        logic eov;
        res_t r;
        cyc++;
        hs0 = 1'b0;
        hs1 = 1'b0;
        if (rst) begin
            sb.delete();
            busy_m = 1'b0;
            last_m = 1'b1;
            chk("rst_ready0", 64'(req0_ready), 64'd0);
            chk("rst_ready1", 64'(req1_ready), 64'd0);
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_man", 64'(out_man), 64'd0);
            chk("rst_exp", 64'(out_exp), 64'd0);
            chk("rst_flags", 64'({out_zero, out_uflow, out_src}), 64'd0);
        end else begin
            er0 = !busy_m && req0_valid && (!req1_valid || last_m);
            er1 = !busy_m && req1_valid && (!req0_valid || !last_m);
            eov = busy_m && (cyc - hs_cyc >= 3);
            chk("ready0", 64'(req0_ready), 64'(er0));
            chk("ready1", 64'(req1_ready), 64'(er1));
            chk("out_valid", 64'(out_valid), 64'(eov));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: got out_valid=1 expected no pending result");
                end else begin
                    r = sb[0];
                    chk("out_man", 64'(out_man), 64'(r.man));
                    chk("out_exp", 64'(out_exp), 64'(r.exp));
                    chk("out_zero", 64'(out_zero), 64'(r.zero));
                    chk("out_uflow", 64'(out_uflow), 64'(r.uflow));
                    chk("out_src", 64'(out_src), 64'(r.src));
                    if (out_ready) begin
                        sb.delete(0);
                        busy_m = 1'b0;
                    end
                end
            end
            if (req0_valid && req0_ready) begin
                sb.push_back(model(req0_man, req0_exp, 1'b0));
                busy_m = 1'b1;
                last_m = 1'b0;
                hs_cyc = cyc;
                hs0    = 1'b1;
                hs_count++;
            end else if (req1_valid && req1_ready) begin
                sb.push_back(model(req1_man, req1_exp, 1'b1));
                busy_m = 1'b1;
                last_m = 1'b1;
                hs_cyc = cyc;
                hs1    = 1'b1;
                hs_count++;
            end
        end
    end

    initial begin
        logic [63:0] t;
        int          hsc;
        int          n;
        rst        = 1'b1;
        out_ready  = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_man   = '0;
        req1_man   = '0;
        req0_exp   = '0;
        req1_exp   = '0;

        // Valid is already presented while reset is held.
        push(0, 48'h0000_0100_0000, 8'd100);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        drain(100);

        push(1, 48'h0, 8'd50);
        drain(100);
        push(0, 48'h0000_0000_0001, 8'd10);
        drain(100);
        // Boundaries: lz equal to exp, exp zero, full-width operand.
        push(0, 48'h0000_8000_0000, 8'd16);
        drain(100);
        push(1, 48'h0000_0000_1234, 8'd0);
        drain(100);
        push(0, 48'hFFFF_FFFF_FFFF, 8'd1);
        drain(100);

        // Both requesters continuously valid.
        for (int i = 0; i < 4; i++) begin
            push(0, 48'h0000_0000_00F0 << (4 * i), 8'(60 + i));
            push(1, 48'h0000_0010_0000 << i, 8'(20 + i));
        end
        drain(300);

        // Backpressure held for six HOLD cycles.
        @(posedge clk);
        #2 out_ready = 1'b0;
        push(1, 48'h0003_0000_0000, 8'd200);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #2 out_ready = 1'b1;
        drain(100);

        // Reset asserted while the transaction is in SHIFT.
        hsc = hs_count;
        push(0, 48'h0000_0F00_0000, 8'd90);
        n = 0;
        while (hs_count == hsc && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (hs_count == hsc) begin
            fails++;
            $display("FAIL rst_midop_handshake: got no handshake expected one within 50 cycles");
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        push(0, 48'h0000_0000_0F00, 8'd40);
        push(1, 48'h0000_0000_00F0, 8'd40);
        drain(200);

        // Randomized traffic with valid gaps, early drops and random backpressure.
        pct      = 50;
        drop_pct = 10;
        for (int i = 0; i < 60; i++) begin
            t = {$urandom(), $urandom()};
            push(i % 2, t[47:0] >> $urandom_range(0, 48),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 50)) : 8'($urandom_range(0, 255)));
        end
        n = 0;
        while (!drained() && n < 5000) begin
            @(posedge clk);
            #2 out_ready = ($urandom_range(0, 99) < 70);
            n++;
        end
        out_ready = 1'b1;
        if (!drained()) begin
            fails++;
            $display("FAIL random_drain_timeout: got pending work expected idle after 5000 cycles");
        end
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
